// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble).
// One conversion per accepted start; busy/done handshake, err flags non-decimal digits.
module bcd_to_bin_seq #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned BW     = 7
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [BW-1:0]         bin,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned WW = 4 * DIGITS;
    localparam int unsigned CW = (BW < 2) ? 1 : $clog2(BW + 1);

    // True when BW bits can hold every DIGITS-digit decimal value.
    function automatic bit width_fits();
        longint unsigned pow10;
        pow10 = 64'd1;
        for (int d = 0; d < int'(DIGITS); d++) begin
            pow10 = pow10 * 64'd10;
        end
        if (BW >= 64) return 1'b1;
        return ((64'd1 << BW) >= pow10);
    endfunction

    localparam bit FITS = width_fits();

    if (!FITS) begin : g_bw_check
        $error("bcd_to_bin_seq: BW too small for DIGITS");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WW-1:0]    work, work_nx;
    logic [BW-1:0]    acc, acc_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [BW-1:0]    bin_nx;
    logic             err_nx;
    logic             busy_nx;
    logic             done_nx;

    logic             digit_bad;
    logic [WW-1:0]    sh_work;
    logic [BW-1:0]    sh_acc;
    logic [WW-1:0]    corr_work;

    // Any input digit above 9 marks the request invalid.
    always_comb begin
        digit_bad = 1'b0;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (bcd[d*4 +: 4] > 4'd9) digit_bad = 1'b1;
        end
    end

    // One right shift of {work, acc}: work LSB enters the accumulator MSB.
    always_comb begin
        sh_work = work >> 1;
        sh_acc  = {work[0], acc[BW-1:1]};
    end

    // Subtract 3 from every shifted digit that reached 8 or more, all in parallel.
    always_comb begin
        logic [3:0] dig;
        corr_work = '0;
        dig       = '0;
        for (int d = 0; d < int'(DIGITS); d++) begin
            dig = sh_work[d*4 +: 4];
            if (dig >= 4'd8) dig = dig - 4'd3;
            corr_work[d*4 +: 4] = dig;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            work  <= '0;
            acc   <= '0;
            cnt   <= '0;
            bin   <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            work  <= work_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            bin   <= bin_nx;
            err   <= err_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        work_nx  = work;
        acc_nx   = acc;
        cnt_nx   = cnt;
        bin_nx   = bin;
        err_nx   = err;

        unique case (state)
            IDLE: begin
                if (start) begin
                    work_nx = bcd;
                    acc_nx  = '0;
                    cnt_nx  = '0;
                    err_nx  = digit_bad;
                    if (digit_bad) begin
                        bin_nx   = '0;
                        state_nx = DONE;
                    end else begin
                        state_nx = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_nx = corr_work;
                acc_nx  = sh_acc;
                cnt_nx  = cnt + CW'(1);
                if (cnt == CW'(BW - 1)) begin
                    bin_nx   = sh_acc;
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == DONE);
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: stimulus pushes expected results, a monitor checks each done pulse.
module tb_bcd_to_bin_seq;

    logic       Clock;
    logic       Resetn;
    logic       start;
    logic [7:0] bcd;
    logic [6:0] bin;
    logic       busy;
    logic       done;
    logic       err;

    bcd_to_bin_seq #(.DIGITS(2), .BW(7)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .start  (start),
        .bcd    (bcd),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    typedef struct {
        logic [6:0] bin;
        logic       err;
        int         cyc;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge Clock) begin
        if (Resetn && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: bin=%0d err=%0d at cycle %0d", bin, err, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_bin"}, int'(bin), int'(e.bin));
                check({e.name, "_err"}, int'(err), int'(e.err));
                check({e.name, "_latency"}, cyc, e.cyc);
                check({e.name, "_busy"}, int'(busy), 1);
            end
        end
    end

    // Drive one start pulse; expected done cycle is capture cycle + 7 (valid) or + 0 (invalid).
    task automatic issue(input logic [7:0] v, input logic [6:0] eb, input logic ee, input string name);
        exp_t e;
        @(negedge Clock);
        start = 1'b1;
        bcd   = v;
        e.bin  = eb;
        e.err  = ee;
        e.cyc  = cyc + 1 + (ee ? 0 : 7);
        e.name = name;
        q.push_back(e);
        @(negedge Clock);
        start = 1'b0;
    endtask

    // Bounded wait until all expectations are consumed and the DUT is back in IDLE.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 40) begin
            @(negedge Clock);
            n++;
        end
        if (q.size() != 0 || busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: pending=%0d busy=%0d, expected 0 and 0", name, q.size(), busy);
            q.delete();
        end
    endtask

    initial begin
        int cap;
        Resetn = 1'b0;
        start  = 1'b0;
        bcd    = 8'h00;
        repeat (3) @(negedge Clock);
        check("reset_bin",  int'(bin),  0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_err",  int'(err),  0);
        Resetn = 1'b1;
        @(negedge Clock);

        // Basic conversion; busy must rise right after capture.
        issue(8'h42, 7'd42, 1'b0, "v42");
        check("v42_busy_rise", int'(busy), 1);
        check("v42_bin_hold_shift", int'(bin), 0);
        wait_idle("v42");

        issue(8'h99, 7'd99, 1'b0, "v99");
        wait_idle("v99");
        issue(8'h00, 7'd0, 1'b0, "v00");
        wait_idle("v00");

        // Start held high: second capture at the first IDLE edge after DONE.
        @(negedge Clock);
        start = 1'b1;
        bcd   = 8'h58;
        cap   = cyc + 1;
        q.push_back('{bin: 7'd58, err: 1'b0, cyc: cap + 7,  name: "held1"});
        q.push_back('{bin: 7'd0,  err: 1'b0, cyc: cap + 16, name: "held2"});
        @(negedge Clock);
        bcd = 8'h00;
        while (cyc < cap + 9) @(negedge Clock);
        start = 1'b0;
        wait_idle("held");

        // Invalid digit: immediate done, err held afterwards.
        issue(8'h1A, 7'd0, 1'b1, "inv1a");
        wait_idle("inv1a");
        repeat (3) @(negedge Clock);
        check("inv1a_err_held", int'(err), 1);
        check("inv1a_bin_held", int'(bin), 0);
        issue(8'h07, 7'd7, 1'b0, "v07");
        check("v07_err_cleared", int'(err), 0);
        wait_idle("v07");
        issue(8'hF3, 7'd0, 1'b1, "invf3");
        wait_idle("invf3");

        // Start during SHIFT is ignored.
        issue(8'h25, 7'd25, 1'b0, "v25");
        @(negedge Clock);
        @(negedge Clock);
        start = 1'b1;
        bcd   = 8'h88;
        @(negedge Clock);
        start = 1'b0;
        wait_idle("v25");
        repeat (12) @(negedge Clock);

        // Asynchronous reset mid-SHIFT aborts without a done pulse.
        issue(8'h63, 7'd63, 1'b0, "abort63");
        @(negedge Clock);
        @(posedge Clock);
        #2;
        Resetn = 1'b0;
        #1;
        check("abort_bin",  int'(bin),  0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_err",  int'(err),  0);
        q.delete();
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        repeat (12) @(negedge Clock);
        issue(8'h63, 7'd63, 1'b0, "v63");
        wait_idle("v63");

        // bcd changes after the capture edge have no effect.
        issue(8'h31, 7'd31, 1'b0, "v31");
        bcd = 8'h77;
        wait_idle("v31");
        repeat (3) @(negedge Clock);
        check("v31_bin_held", int'(bin), 31);
        check("final_queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
